// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths, fetch-state encoding and
// the value presented to the IR when no instruction is available.
package cpu_pkg;

    localparam int CPU_ADDR_W = 4;
    localparam int CPU_DATA_W = 8;

    localparam logic [7:0] INSTR_RESET = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        FLUSH = 2'd3
    } fetchState_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO with a registered head word so the
// consumer sees a stable, registered output that reads EMPTY_VAL when empty.
module fetch_fifo #(
    parameter int               WIDTH     = 12,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] EMPTY_VAL = '0,
    localparam int              PTR_W     = $clog2(DEPTH),
    localparam int              CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] headData,
    output logic             headValid
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;

    logic             popOk;
    logic             pushOk;
    logic [CNT_W-1:0] remain;
    logic [CNT_W-1:0] countNext;
    logic [WIDTH-1:0] headDataNext;
    logic             headValidNext;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Flush dominates both push and pop; a push into a full buffer is only
    // accepted when the same cycle frees a slot.
    always_comb begin
        popOk         = pop & ~empty & ~flush;
        pushOk        = push & ~flush & (~full | popOk);
        remain        = count - CNT_W'(popOk);
        countNext     = flush ? '0 : remain + CNT_W'(pushOk);
        headValidNext = 1'b0;
        headDataNext  = EMPTY_VAL;
        if (!flush) begin
            if (remain != '0) begin
                headValidNext = 1'b1;
                headDataNext  = mem[rdPtr + PTR_W'(popOk)];
            end else if (pushOk) begin
                headValidNext = 1'b1;
                headDataNext  = pushData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            count     <= '0;
            headValid <= 1'b0;
            headData  <= EMPTY_VAL;
        end else begin
            count     <= countNext;
            headValid <= headValidNext;
            headData  <= headDataNext;
            if (flush) begin
                rdPtr <= '0;
                wrPtr <= '0;
            end else begin
                if (popOk) begin
                    rdPtr <= rdPtr + PTR_W'(1);
                end
                if (pushOk) begin
                    wrPtr <= wrPtr + PTR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues single outstanding reads to program memory,
// buffers returned words with their address and hands them to the IR.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = CPU_ADDR_W,
    parameter int DATA_W     = CPU_DATA_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              LoadIR,
    input  logic              LoadPC,
    input  logic [ADDR_W-1:0] PCIn
);

    localparam int ENTRY_W = DATA_W + ADDR_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    fetchState_e       state;
    fetchState_e       stateNext;
    logic [ADDR_W-1:0] fetchPc;
    logic [ADDR_W-1:0] fetchPcNext;
    logic [ADDR_W-1:0] issuedAddr;
    logic              readPending;

    logic               push;
    logic               pop;
    logic               fifoFull;
    logic               fifoEmpty;
    logic [CNT_W-1:0]   fifoCount;
    logic [ENTRY_W-1:0] headData;
    logic               headValid;
    logic               roomIdle;
    logic               roomAfterPush;

    // A jump discards both the same-cycle pop and any word returning this cycle.
    assign pop  = LoadIR & ~fifoEmpty & ~LoadPC;
    assign push = (state == WAIT) & mem_rvalid & ~LoadPC;

    assign roomIdle      = ~fifoFull | pop;
    assign roomAfterPush = (fifoCount + CNT_W'(1) - CNT_W'(pop)) < CNT_W'(FIFO_DEPTH);

    assign mem_req  = (state == ISSUE);
    assign mem_addr = fetchPc;

    // FLUSH leaves once the dropped read has returned; with nothing in flight
    // (jump landed on the return cycle) it moves straight on to ISSUE.
    always_comb begin
        stateNext   = state;
        fetchPcNext = fetchPc;
        case (state)
            IDLE: begin
                if (roomIdle) begin
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                fetchPcNext = fetchPc + ADDR_W'(1);
                stateNext   = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    stateNext = roomAfterPush ? ISSUE : IDLE;
                end
            end
            FLUSH: begin
                if (mem_rvalid || !readPending) begin
                    stateNext = ISSUE;
                end
            end
            default: stateNext = IDLE;
        endcase
        if (LoadPC) begin
            fetchPcNext = PCIn;
            stateNext   = (state == IDLE) ? ISSUE : FLUSH;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            fetchPc     <= '0;
            readPending <= 1'b0;
        end else begin
            state       <= stateNext;
            fetchPc     <= fetchPcNext;
            readPending <= (state == ISSUE) | (readPending & ~mem_rvalid);
        end
    end

    always_ff @(posedge clk) begin
        if (state == ISSUE) begin
            issuedAddr <= fetchPc;
        end
    end

    fetch_fifo #(
        .WIDTH     (ENTRY_W),
        .DEPTH     (FIFO_DEPTH),
        .EMPTY_VAL ({DATA_W'(INSTR_RESET), ADDR_W'(0)})
    ) u_fetchFifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pushData  ({mem_rdata, issuedAddr}),
        .pop       (pop),
        .flush     (LoadPC),
        .count     (fifoCount),
        .full      (fifoFull),
        .empty     (fifoEmpty),
        .headData  (headData),
        .headValid (headValid)
    );

    assign instruction = headData[ENTRY_W-1:ADDR_W];
    assign instr_pc    = headData[ADDR_W-1:0];
    assign instr_valid = headValid;

endmodule
